// File: rtl/bridge_pkg.sv
// Shared constants for the UART/JTAG bridge: byte width and default FIFO depth.
package bridge_pkg;
    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 16;
endpackage

// File: rtl/bridge_fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage with synchronous write and a registered read port.
module bridge_fifo_mem
    import bridge_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Only the output register is cleared; it holds until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (clr) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/bridge_byte_fifo.sv
// Single-clock byte FIFO with registered read data, occupancy, thresholds and sticky errors.
module bridge_byte_fifo
    import bridge_pkg::*;
#(
    parameter int WIDTH    = BYTE_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // Accepts look only at registered status, so a same-cycle read never frees room for a write.
    assign w_wr_acc = wr_en && !w_full  && !clr;
    assign w_rd_acc = rd_en && !w_empty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - 1'b1;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    bridge_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr),
        .wdata (wr_data),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr),
        .rdata (rd_data)
    );

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign almost_full  = (int'(r_count) >= AF_LEVEL);
    assign almost_empty = (int'(r_count) <= AE_LEVEL);

endmodule

// File: tb/tb_bridge_byte_fifo.sv
// Directed self-checking bench for bridge_byte_fifo (WIDTH=8, DEPTH=16).
module tb_bridge_byte_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       full;
    logic       almost_full;
    logic [7:0] rd_data;
    logic       empty;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    bridge_byte_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cycle();
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        cycle();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        n_checks++;
        if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 101000", {empty, full, almost_empty, almost_full, overflow, underflow});
        end
        n_checks++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        $display("reset: count=%0d empty=%b rd_data=%h", count, empty, rd_data);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            do_write(8'(i));
            n_checks++;
            if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", count, i + 1); end
            n_checks++;
            if (almost_full !== (i + 1 >= 14)) begin n_fail++; $display("FAIL fill_almost_full: got %b expected %b at count %0d", almost_full, (i + 1 >= 14), i + 1); end
            n_checks++;
            if (full !== (i == 15)) begin n_fail++; $display("FAIL fill_full: got %b expected %b", full, (i == 15)); end
            $display("fill: wrote %h count=%0d full=%b almost_full=%b", 8'(i), count, full, almost_full);
        end
        for (int i = 0; i < 16; i++) begin
            do_read();
            n_checks++;
            if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data: got %h expected %h", rd_data, 8'(i)); end
            n_checks++;
            if (count !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_count: got %0d expected %0d", count, 15 - i); end
            n_checks++;
            if (almost_empty !== (15 - i <= 2)) begin n_fail++; $display("FAIL drain_almost_empty: got %b expected %b", almost_empty, (15 - i <= 2)); end
            $display("drain: read %h count=%0d", rd_data, count);
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 16; i++) do_write(8'(i));
        do_write(8'hAA);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++;
        if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", count); end
        $display("overflow: write AA while full, overflow=%b count=%0d", overflow, count);
        for (int i = 0; i < 16; i++) begin
            do_read();
            n_checks++;
            if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain_data: got %h expected %h", rd_data, 8'(i)); end
        end
        do_read();
        n_checks++;
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b expected 1", underflow); end
        n_checks++;
        if (rd_data !== 8'h0F) begin n_fail++; $display("FAIL unf_hold: got %h expected 0f", rd_data); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        $display("underflow: read while empty, underflow=%b rd_data=%h", underflow, rd_data);
        do_clr();
        n_checks++;
        if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL clr_flags: got %b expected 00", {overflow, underflow}); end
        n_checks++;
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL clr_rd_data: got %h expected 00", rd_data); end
        $display("clr: overflow=%b underflow=%b", overflow, underflow);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) do_write(8'(8'h50 + i));
        wr_en = 1'b1; wr_data = 8'h55; rd_en = 1'b1;
        cycle();
        n_checks++;
        if (count !== 5'd5) begin n_fail++; $display("FAIL simul_mid_count: got %0d expected 5", count); end
        n_checks++;
        if (rd_data !== 8'h50) begin n_fail++; $display("FAIL simul_mid_data: got %h expected 50", rd_data); end
        $display("simul mid: count=%0d rd_data=%h", count, rd_data);
        for (int i = 1; i <= 5; i++) begin
            do_read();
            n_checks++;
            if (rd_data !== 8'(8'h50 + i)) begin n_fail++; $display("FAIL simul_mid_drain: got %h expected %h", rd_data, 8'(8'h50 + i)); end
        end

        do_clr();
        for (int i = 0; i < 16; i++) do_write(8'(8'h60 + i));
        wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
        cycle();
        n_checks++;
        if (count !== 5'd15) begin n_fail++; $display("FAIL simul_full_count: got %0d expected 15", count); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL simul_full_ovf: got %b expected 1", overflow); end
        n_checks++;
        if (rd_data !== 8'h60) begin n_fail++; $display("FAIL simul_full_data: got %h expected 60", rd_data); end
        $display("simul full: count=%0d overflow=%b rd_data=%h", count, overflow, rd_data);
        for (int i = 1; i < 16; i++) begin
            do_read();
            n_checks++;
            if (rd_data !== 8'(8'h60 + i)) begin n_fail++; $display("FAIL simul_full_drain: got %h expected %h", rd_data, 8'(8'h60 + i)); end
        end

        do_clr();
        wr_en = 1'b1; wr_data = 8'h77; rd_en = 1'b1;
        cycle();
        n_checks++;
        if (count !== 5'd1) begin n_fail++; $display("FAIL simul_empty_count: got %0d expected 1", count); end
        n_checks++;
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL simul_empty_unf: got %b expected 1", underflow); end
        n_checks++;
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL simul_empty_hold: got %h expected 00", rd_data); end
        do_read();
        n_checks++;
        if (rd_data !== 8'h77) begin n_fail++; $display("FAIL simul_empty_data: got %h expected 77", rd_data); end
        $display("simul empty: underflow=%b rd_data=%h", underflow, rd_data);
    endtask

    task automatic test_wrap();
        do_clr();
        for (int k = 0; k < 3; k++) do_write(8'(8'h10 + k));
        for (int k = 3; k < 40; k++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + k); rd_en = 1'b1;
            cycle();
            n_checks++;
            if (rd_data !== 8'(8'h10 + k - 3)) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", rd_data, 8'(8'h10 + k - 3)); end
            n_checks++;
            if (count !== 5'd3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", count); end
            $display("wrap: wrote %h read %h count=%0d", 8'(8'h10 + k), rd_data, count);
        end
        for (int k = 37; k < 40; k++) begin
            do_read();
            n_checks++;
            if (rd_data !== 8'(8'h10 + k)) begin n_fail++; $display("FAIL wrap_tail: got %h expected %h", rd_data, 8'(8'h10 + k)); end
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_mid_reset();
        do_clr();
        for (int i = 0; i < 8; i++) do_write(8'(8'hC0 + i));
        do_read();
        n_checks++;
        if (count !== 5'd7 || rd_data !== 8'hC0) begin n_fail++; $display("FAIL pre_reset: got count=%0d data=%h expected count=7 data=c0", count, rd_data); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d empty=%b ae=%b data=%h expected 0 1 1 00", count, empty, almost_empty, rd_data);
        end
        $display("async reset: count=%0d empty=%b rd_data=%h", count, empty, rd_data);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) do_write(8'(8'hD0 + i));
        clr = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        cycle();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_with_write: got count=%0d empty=%b ovf=%b expected 0 1 0", count, empty, overflow);
        end
        clr = 1'b1; rd_en = 1'b1;
        cycle();
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL clr_with_read: got underflow=%b expected 0", underflow); end
        do_write(8'h3C);
        do_read();
        n_checks++;
        if (rd_data !== 8'h3C || count !== 5'd0) begin n_fail++; $display("FAIL post_clr: got data=%h count=%0d expected 3c 0", rd_data, count); end
        $display("clr+write: count=%0d next read %h", count, rd_data);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
